addr_latch_32_1_bit: RTL and testbench
======================================

ADDR_LATCH_32_1_BIT -- requirements
Module: addr_latch_32_1_bit

Interface
REQ-001 The block SHALL have parameter CLR_VALUE, default 1'b0, the bit value written to every position during a sweep.
REQ-002 The block SHALL have parameter PROTECT_BIT0, default 0; when 1, out[0] is held at 0 permanently, like register $r0.
REQ-003 The block SHALL have port clock  input  1  rising-edge clock; single clock domain.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port select  input  5  bit address for a single write.
REQ-006 The block SHALL have port in  input  1  data bit to be written.
REQ-007 The block SHALL have port wr_en  input  1  write request, sampled at the rising edge.
REQ-008 The block SHALL have port clr_req  input  1  sweep request, level-sampled only in IDLE.
REQ-009 The block SHALL have port out  output  32  registered latch contents; out[i] is the bit stored at address i.
REQ-010 The block SHALL have port busy  output  1  registered; high while state is SWEEP.
REQ-011 The block SHALL have port done  output  1  registered one-cycle pulse marking sweep completion.

Function
REQ-012 The block SHALL implement a 1-to-32 registered demultiplexer: the 5-bit select decodes to a one-hot enable over 32 storage flops.
REQ-013 The FSM SHALL have exactly three states: IDLE, SWEEP and DONE.
REQ-014 In IDLE with wr_en=1 and clr_req=0, the block SHALL load out[select] <= in at the edge; all other bits are unchanged; new value is visible the cycle after the edge (latency 1).
REQ-015 In IDLE with clr_req=1, the block SHALL transition to SWEEP at the edge and clear the 5-bit sweep counter to 0.
REQ-016 In IDLE with clr_req=1, any wr_en in the same cycle SHALL be dropped (clr_req has priority).
REQ-017 In SWEEP, the block SHALL write out[cnt] <= CLR_VALUE each edge and increment cnt by 1.
REQ-018 The SWEEP counter SHALL take exactly 32 edges (cnt 0..31); at cnt=31 the write occurs, the state moves to DONE, and cnt wraps to 0.
REQ-019 In DONE, the block SHALL hold done=1 for exactly one cycle and return to IDLE at the next edge.
REQ-020 In DONE, the block SHALL ignore wr_en and clr_req.
REQ-021 In SWEEP and DONE, wr_en SHALL be ignored with no storage change; the requester observes busy/done and retries.
REQ-022 If clr_req is still high on return to IDLE, a new sweep SHALL start at the next edge (level-sensitive, no edge detect).
REQ-023 With PROTECT_BIT0=1, writes and sweep writes to address 0 SHALL have no effect and out[0] SHALL always read 0.
REQ-024 busy SHALL be 1 exactly when the state is SWEEP.
REQ-025 done SHALL be 1 exactly when the state is DONE.
REQ-026 The block SHALL produce no X on out for any select value; all 32 addresses are valid.

Reset
REQ-027 When reset=0, the block SHALL immediately and asynchronously force out=32'h0, busy=0, done=0, state=IDLE and cnt=0, regardless of clock.
REQ-028 Assertion of reset mid-sweep SHALL abort the sweep; after release no done pulse is issued and the block is in IDLE.
REQ-029 After reset deassertion, the first edge SHALL be a normal IDLE cycle.

Verification
REQ-030 Bench SHALL check: reset, then writes of 1 to select=3, 17, 31 -> out=32'h8002_0008 one cycle after the last write; busy=0, done=0.
REQ-031 Bench SHALL check: out=32'hFFFF_FFFF (PROTECT_BIT0=0, CLR_VALUE=0), clr_req pulsed 1 cycle -> busy high 32 cycles, bits clear LSB-first, then done=1 for 1 cycle, out=0, busy=0.
REQ-032 Bench SHALL check: wr_en=1 with select=5, in=1 during SWEEP cycle 10 -> write ignored, out[5]=0 after sweep.
REQ-033 Bench SHALL check: wr_en=1 and clr_req=1 in the same IDLE cycle -> write dropped, sweep starts; clr_req held high -> second sweep starts one cycle after done.
REQ-034 Bench SHALL check: reset=0 asserted asynchronously at sweep cycle 12 -> out=0 and busy=0 before the next edge, with no done pulse afterward.
REQ-035 Bench SHALL check: PROTECT_BIT0=1 and CLR_VALUE=1, with write 1 to select=0, then sweep -> out=32'hFFFF_FFFE.

Source files
------------

// File: rtl/addr_latch_32_1_bit.sv
// addr_latch_32_1_bit
//   32 x 1-bit addressable latch built as a registered 1-to-32 demultiplexer,
//   with a background sweep that writes CLR_VALUE to every address, LSB first.
//
//   Parameters
//     CLR_VALUE    : bit value written to every address during a sweep
//     PROTECT_BIT0 : when 1, address 0 behaves like a hard-wired zero register
//
//   Ports
//     clock   : rising-edge clock, single domain
//     reset   : asynchronous active-low reset
//     select  : 5-bit address for a single write
//     in      : data bit to be written
//     wr_en   : write request, honoured only in IDLE without clr_req
//     clr_req : sweep request, level-sampled in IDLE
//     out     : registered latch contents, out[i] = bit at address i
//     busy    : registered, high while a sweep is in progress
//     done    : registered one-cycle pulse at sweep completion
module addr_latch_32_1_bit #(
  parameter logic CLR_VALUE    = 1'b0,
  parameter bit   PROTECT_BIT0 = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  select,
  input  logic        in,
  input  logic        wr_en,
  input  logic        clr_req,
  output logic [31:0] out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] wr_mask;
  logic        wr_bit;
  logic [31:0] keep_mask;
  logic [31:0] next_out;

  // One-hot enable for the addressed storage flop.
  function automatic logic [31:0] decode_5to32(input logic [4:0] addr);
    decode_5to32 = 32'd1 << addr;
  endfunction

  // Select which flop is written this cycle and with what value.
  always_comb begin
    wr_mask = 32'd0;
    wr_bit  = 1'b0;
    case (state)
      IDLE: begin
        // clr_req wins over a simultaneous write request
        if (wr_en && !clr_req) begin
          wr_mask = decode_5to32(select);
          wr_bit  = in;
        end else begin
          wr_mask = 32'd0;
          wr_bit  = 1'b0;
        end
      end
      SWEEP: begin
        wr_mask = decode_5to32(cnt);
        wr_bit  = CLR_VALUE;
      end
      DONE: begin
        wr_mask = 32'd0;
        wr_bit  = 1'b0;
      end
      default: begin
        wr_mask = 32'd0;
        wr_bit  = 1'b0;
      end
    endcase
  end

  // Masked merge of the write into the stored word; bit 0 optionally pinned low.
  always_comb begin
    if (PROTECT_BIT0) begin
      keep_mask = 32'hFFFF_FFFE;
    end else begin
      keep_mask = 32'hFFFF_FFFF;
    end
    next_out = ((out & ~wr_mask) | (wr_mask & {32{wr_bit}})) & keep_mask;
  end

  // Control FSM, sweep counter, storage and registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 5'd0;
      out   <= 32'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      out <= next_out;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= SWEEP;
            cnt   <= 5'd0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        SWEEP: begin
          // counter wraps 31 -> 0 on the final sweep write
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= 5'd0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addr_latch_32_1_bit.sv
// Testbench for addr_latch_32_1_bit: a default instance and a protected
// instance (PROTECT_BIT0=1, CLR_VALUE=1) share all inputs and are compared
// every cycle against a behavioural model, plus directed scenario checks.
module tb_addr_latch_32_1_bit;

  logic        clock;
  logic        reset;
  logic [4:0]  select;
  logic        in;
  logic        wr_en;
  logic        clr_req;
  logic [31:0] out0, out1;
  logic        busy0, busy1, done0, done1;

  int n_checks = 0;
  int n_errors = 0;

  // Model: stored words, next sweep address (-1 = no sweep), done pending.
  bit [31:0] m_out   [2];
  int        m_sweep [2];
  bit        m_done  [2];
  bit        m_prot  [2];
  bit        m_clrv  [2];

  addr_latch_32_1_bit dut0 (
    .clock(clock), .reset(reset), .select(select), .in(in), .wr_en(wr_en),
    .clr_req(clr_req), .out(out0), .busy(busy0), .done(done0)
  );

  addr_latch_32_1_bit #(.CLR_VALUE(1'b1), .PROTECT_BIT0(1'b1)) dut1 (
    .clock(clock), .reset(reset), .select(select), .in(in), .wr_en(wr_en),
    .clr_req(clr_req), .out(out1), .busy(busy1), .done(done1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k]   = 32'd0;
      m_sweep[k] = -1;
      m_done[k]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (m_done[k]) begin
        m_done[k] = 1'b0;
      end else if (m_sweep[k] >= 0) begin
        m_out[k][m_sweep[k]] = m_clrv[k];
        m_sweep[k]++;
        if (m_sweep[k] == 32) begin
          m_sweep[k] = -1;
          m_done[k]  = 1'b1;
        end
      end else if (clr_req) begin
        m_sweep[k] = 0;
      end else if (wr_en) begin
        m_out[k][select] = in;
      end
      if (m_prot[k]) m_out[k][0] = 1'b0;
    end
  endtask

  task automatic compare_all(input string phase);
    check_eq({phase, ".out0"},  out0,  m_out[0]);
    check_eq({phase, ".busy0"}, {31'd0, busy0}, {31'd0, m_sweep[0] >= 0});
    check_eq({phase, ".done0"}, {31'd0, done0}, {31'd0, m_done[0]});
    check_eq({phase, ".out1"},  out1,  m_out[1]);
    check_eq({phase, ".busy1"}, {31'd0, busy1}, {31'd0, m_sweep[1] >= 0});
    check_eq({phase, ".done1"}, {31'd0, done1}, {31'd0, m_done[1]});
  endtask

  // One clock edge: update model with the inputs present at the edge, then compare.
  task automatic tick(input string phase);
    @(posedge clock);
    if (reset) model_edge();
    #1;
    compare_all(phase);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; clr_req = 1'b0; select = 5'd0; in = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    m_prot[0] = 1'b0; m_clrv[0] = 1'b0;
    m_prot[1] = 1'b1; m_clrv[1] = 1'b1;
    model_reset();
    idle_inputs();

    // Reset state, before any clock edge
    reset = 1'b0;
    #2;
    compare_all("reset");
    @(negedge clock);
    reset = 1'b1;

    // Single writes to 3, 17, 31
    wr_en = 1'b1; in = 1'b1;
    select = 5'd3;  tick("wr3");
    select = 5'd17; tick("wr17");
    select = 5'd31; tick("wr31");
    idle_inputs();
    check_eq("pattern0", out0, 32'h8002_0008);
    check_eq("pattern0.busy", {31'd0, busy0}, 32'd0);
    check_eq("pattern0.done", {31'd0, done0}, 32'd0);

    // Fill every address with 1 (address 0 included)
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; in = 1'b1; select = 5'(i);
      tick("fill");
    end
    idle_inputs();
    check_eq("fill.out0", out0, 32'hFFFF_FFFF);
    check_eq("fill.out1", out1, 32'hFFFF_FFFE);

    // Sweep from a one-cycle clr_req pulse, with a write attempt at sweep cycle 10
    clr_req = 1'b1;
    tick("sw_start");
    clr_req = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 32; c++) begin
      if (busy0) busy_cycles++;
      if (c == 10) begin
        wr_en = 1'b1; select = 5'd5; in = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
      tick("sweep");
    end
    idle_inputs();
    check_eq("sweep.busy_cycles", busy_cycles, 32'd32);
    check_eq("sweep.done", {31'd0, done0}, 32'd1);
    check_eq("sweep.out0", out0, 32'd0);
    check_eq("sweep.bit5", {31'd0, out0[5]}, 32'd0);
    check_eq("protect.out1", out1, 32'hFFFF_FFFE);
    tick("post_done");
    check_eq("post_done.done", {31'd0, done0}, 32'd0);

    // wr_en with clr_req: write dropped; clr_req held -> back-to-back sweeps
    wr_en = 1'b1; select = 5'd9; in = 1'b1; clr_req = 1'b1;
    tick("prio");
    wr_en = 1'b0;
    check_eq("prio.busy", {31'd0, busy0}, 32'd1);
    check_eq("prio.bit9", {31'd0, out0[9]}, 32'd0);
    for (int c = 0; c < 32; c++) tick("sweep2");
    check_eq("sweep2.done", {31'd0, done0}, 32'd1);
    tick("gap");
    check_eq("gap.busy", {31'd0, busy0}, 32'd0);
    tick("restart");
    check_eq("restart.busy", {31'd0, busy0}, 32'd1);
    clr_req = 1'b0;
    for (int c = 0; c < 33; c++) tick("sweep3");

    // Fill some ones, then async reset at sweep cycle 12
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; in = 1'b1; select = 5'(i * 4 + 2);
      tick("refill");
    end
    idle_inputs();
    clr_req = 1'b1;
    tick("sw4_start");
    clr_req = 1'b0;
    for (int c = 0; c < 12; c++) tick("sweep4");
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("arst.out0", out0, 32'd0);
    check_eq("arst.busy0", {31'd0, busy0}, 32'd0);
    check_eq("arst.done0", {31'd0, done0}, 32'd0);
    check_eq("arst.out1", out1, 32'd0);
    tick("in_reset");
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 40; c++) tick("after_rst");

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      wr_en   = 1'($urandom_range(0, 1));
      select  = 5'($urandom_range(0, 31));
      in      = 1'($urandom_range(0, 1));
      clr_req = ($urandom_range(0, 19) == 0);
      tick("rand");
    end
    idle_inputs();
    for (int c = 0; c < 40; c++) tick("drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
